// File: rtl/lfsr_checker.sv
// lfsr_checker: receive-side checker for the 16-bit XNOR pattern generator
// (taps 15,14,12,3, shift left, new bit enters at bit 0). Self-synchronises
// to the incoming serial stream, then flywheels on its own prediction and
// flags/counts bit errors.
// Optional macro LFSR_CHK_SEED_EN adds seed_load/seed ports for zero-latency
// lock when the checker shares the generator's seed.
module lfsr_checker #(
    parameter int LOCK_CNT    = 16,
    parameter int LOSS_THRESH = 4,
    parameter int ERR_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_err,
`ifdef LFSR_CHK_SEED_EN
    input  logic             seed_load,
    input  logic [15:0]      seed,
`endif
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int LW = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t           state, state_n;
    logic [15:0]      h, h_n;
    logic [3:0]       fill_cnt, fill_n;
    logic [MW-1:0]    match_cnt, match_n;
    logic [LW-1:0]    miss_cnt, miss_n;
    logic             err_pulse_n;
    logic [ERR_W-1:0] err_count_n;
    logic             err_hit;
    logic             p;

    // Next bit the generator will emit, given the last 16 received bits.
    assign p      = ~(h[15] ^ h[14] ^ h[12] ^ h[3]);
    assign locked = (state == LOCKED);

    // State and counter registers; reset discards lock and all counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= HUNT;
            h         <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            h         <= h_n;
            fill_cnt  <= fill_n;
            match_cnt <= match_n;
            miss_cnt  <= miss_n;
            err_pulse <= err_pulse_n;
            err_count <= err_count_n;
        end
    end

    // Next-state: fill, sliding verify, then flywheel with loss detection.
    always_comb begin
        state_n     = state;
        h_n         = h;
        fill_n      = fill_cnt;
        match_n     = match_cnt;
        miss_n      = miss_cnt;
        err_pulse_n = 1'b0;
        err_hit     = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    h_n    = {h[14:0], in_bit};
                    fill_n = fill_cnt + 4'd1;
                    if (fill_cnt == 4'd15) begin
                        state_n = VERIFY;
                        match_n = '0;
                    end
                end
                VERIFY: begin
                    h_n = {h[14:0], in_bit};
                    if (in_bit == p) begin
                        match_n = match_cnt + 1'b1;
                        if (match_cnt == MW'(LOCK_CNT - 1)) begin
                            state_n = LOCKED;
                            miss_n  = '0;
                        end
                    end else begin
                        // Restart the run; the history already holds the
                        // received bits, so resync slides forward.
                        match_n = '0;
                    end
                end
                LOCKED: begin
                    // Shift in the prediction so isolated errors never
                    // corrupt the history.
                    h_n = {h[14:0], p};
                    if (in_bit == p) begin
                        miss_n = '0;
                    end else begin
                        err_hit     = 1'b1;
                        err_pulse_n = 1'b1;
                        miss_n      = miss_cnt + 1'b1;
                        if (miss_cnt == LW'(LOSS_THRESH - 1)) begin
                            state_n = HUNT;
                            fill_n  = '0;
                            match_n = '0;
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
`ifdef LFSR_CHK_SEED_EN
        if (seed_load) begin
            h_n         = seed;
            state_n     = LOCKED;
            miss_n      = '0;
            err_pulse_n = 1'b0;
            err_hit     = 1'b0;
        end
`endif
        // Clear wins over a simultaneous error; count saturates at all-ones.
        err_count_n = err_count;
        if (clr_err)
            err_count_n = '0;
        else if (err_hit && (err_count != '1))
            err_count_n = err_count + 1'b1;
    end
endmodule
